ahb_lite_master: RTL

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_lite_pkg.sv | 40 ++++
 rtl/ahb_lite_lane_rep.sv | 43 ++++
 rtl/ahb_lite_master.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings (HTRANS/HSIZE/HBURST) and the master's address-phase state type.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'b000,
        HSIZE_HALF   = 3'b001,
        HSIZE_WORD   = 3'b010,
        HSIZE_DWORD  = 3'b011,
        HSIZE_4WORD  = 3'b100,
        HSIZE_8WORD  = 3'b101,
        HSIZE_16WORD = 3'b110,
        HSIZE_32WORD = 3'b111
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // ADDR_HOLD parks a command behind a two-cycle ERROR before it is re-issued.
    typedef enum logic [1:0] {
        ADDR_EMPTY  = 2'b00,
        ADDR_ACTIVE = 2'b01,
        ADDR_HOLD   = 2'b10
    } addrState_e;

endpackage

// File: rtl/ahb_lite_lane_rep.sv
// Byte-lane helper: replicates narrow write data across all lanes and extracts
// the addressed lane of narrow read data, zero-extended to bit 0.
module ahb_lite_lane_rep
    import ahb_lite_pkg::*;
#(
    parameter int HDATA_WIDTH = 32
) (
    input  logic [HDATA_WIDTH-1:0]             wdata_i,
    input  logic [2:0]                         wsize_i,
    input  logic [HDATA_WIDTH-1:0]             rdata_i,
    input  logic [$clog2(HDATA_WIDTH/8)-1:0]   rlane_i,
    input  logic [2:0]                         rsize_i,
    output logic [HDATA_WIDTH-1:0]             wdata_o,
    output logic [HDATA_WIDTH-1:0]             rdata_o
);

    localparam int NB = HDATA_WIDTH / 8;

    logic [HDATA_WIDTH-1:0] shifted;
    logic [HDATA_WIDTH-1:0] mask;

    always_comb begin
        case (wsize_i)
            HSIZE_BYTE: wdata_o = {NB{wdata_i[7:0]}};
            HSIZE_HALF: wdata_o = {(NB / 2){wdata_i[15:0]}};
            HSIZE_WORD: wdata_o = {(NB / 4){wdata_i[31:0]}};
            default:    wdata_o = wdata_i;
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {rlane_i, 3'b000};
        mask    = '0;
        case (rsize_i)
            HSIZE_BYTE: mask[7:0]  = '1;
            HSIZE_HALF: mask[15:0] = '1;
            HSIZE_WORD: mask[31:0] = '1;
            default:    mask       = '1;
        endcase
        rdata_o = shifted & mask;
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer pipelined AHB-Lite master with two-cycle ERROR re-issue.
// Define AHB_LITE_MASTER_LANE_REP_EN to enable narrow-transfer lane replicate/extract.
module ahb_lite_master
    import ahb_lite_pkg::*;
#(
    parameter int HADDR_WIDTH = 32,
    parameter int HDATA_WIDTH = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [HADDR_WIDTH-1:0] cmd_addr,
    input  logic                   cmd_write,
    input  logic [2:0]             cmd_size,
    input  logic [HDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic [HDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic [HADDR_WIDTH-1:0] HADDR,
    output logic [1:0]             HTRANS,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic                   HWRITE,
    output logic [HDATA_WIDTH-1:0] HWDATA,
    input  logic [HDATA_WIDTH-1:0] HRDATA,
    input  logic                   HREADY,
    input  logic                   HRESP
);

    localparam int LANE_W = $clog2(HDATA_WIDTH / 8);

    addrState_e             aState_q, aState_d;
    htrans_e                htrans_q;
    logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [2:0]             hsize_q, hsize_d;
    logic                   hwrite_q, hwrite_d;
    logic [HDATA_WIDTH-1:0] aWdata_q, aWdata_d;
    logic                   dValid_q, dValid_d;
    logic                   dWrite_q, dWrite_d;
    logic [HDATA_WIDTH-1:0] hwdata_q, hwdata_d;

    logic                   cmdReady;
    logic                   accept;
    logic                   addrMove;
    logic                   errFirst;
    logic [HDATA_WIDTH-1:0] wdataLane;
    logic [HDATA_WIDTH-1:0] rdataLane;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            aState_q <= ADDR_EMPTY;
            htrans_q <= HTRANS_IDLE;
        end else begin
            aState_q <= aState_d;
            htrans_q <= (aState_d == ADDR_ACTIVE) ? HTRANS_NONSEQ : HTRANS_IDLE;
        end
    end

    always_comb begin
        aState_d = aState_q;
        case (aState_q)
            ADDR_EMPTY:  if (accept) aState_d = ADDR_ACTIVE;
            ADDR_ACTIVE: begin
                if (errFirst)
                    aState_d = ADDR_HOLD;
                else if (addrMove && !accept)
                    aState_d = ADDR_EMPTY;
            end
            ADDR_HOLD:   if (HREADY) aState_d = ADDR_ACTIVE;
            default:     aState_d = ADDR_EMPTY;
        endcase
    end

    always_comb begin
        cmdReady = !HRESET && (aState_q != ADDR_HOLD) && ((aState_q == ADDR_EMPTY) || HREADY);
        accept   = cmd_valid && cmdReady;
        addrMove = (aState_q == ADDR_ACTIVE) && HREADY;
        errFirst = dValid_q && HRESP && !HREADY && (aState_q == ADDR_ACTIVE);
    end

    // Address-phase command is reloaded only on accept; data phase advances only on HREADY.
    always_comb begin
        haddr_d  = haddr_q;
        hsize_d  = hsize_q;
        hwrite_d = hwrite_q;
        aWdata_d = aWdata_q;
        dValid_d = dValid_q;
        dWrite_d = dWrite_q;
        hwdata_d = hwdata_q;
        if (accept) begin
            haddr_d  = cmd_addr;
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            aWdata_d = cmd_write ? wdataLane : '0;
        end
        if (HREADY) begin
            dValid_d = addrMove;
            if (addrMove) begin
                dWrite_d = hwrite_q;
                hwdata_d = aWdata_q;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            haddr_q  <= '0;
            hsize_q  <= HSIZE_BYTE;
            hwrite_q <= 1'b0;
            aWdata_q <= '0;
            dValid_q <= 1'b0;
            dWrite_q <= 1'b0;
            hwdata_q <= '0;
        end else begin
            haddr_q  <= haddr_d;
            hsize_q  <= hsize_d;
            hwrite_q <= hwrite_d;
            aWdata_q <= aWdata_d;
            dValid_q <= dValid_d;
            dWrite_q <= dWrite_d;
            hwdata_q <= hwdata_d;
        end
    end

`ifdef AHB_LITE_MASTER_LANE_REP_EN
    logic [LANE_W-1:0] dLane_q, dLane_d;
    logic [2:0]        dSize_q, dSize_d;

    always_comb begin
        dLane_d = dLane_q;
        dSize_d = dSize_q;
        if (addrMove) begin
            dLane_d = haddr_q[LANE_W-1:0];
            dSize_d = hsize_q;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dLane_q <= '0;
            dSize_q <= HSIZE_BYTE;
        end else begin
            dLane_q <= dLane_d;
            dSize_q <= dSize_d;
        end
    end

    ahb_lite_lane_rep #(
        .HDATA_WIDTH (HDATA_WIDTH)
    ) u_laneRep (
        .wdata_i (cmd_wdata),
        .wsize_i (cmd_size),
        .rdata_i (HRDATA),
        .rlane_i (dLane_q),
        .rsize_i (dSize_q),
        .wdata_o (wdataLane),
        .rdata_o (rdataLane)
    );
`else
    assign wdataLane = cmd_wdata;
    assign rdataLane = HRDATA;
`endif

    always_comb begin
        rsp_valid = !HRESET && dValid_q && HREADY;
        rsp_err   = rsp_valid && HRESP;
        rsp_rdata = (rsp_valid && !dWrite_q) ? rdataLane : '0;
    end

    assign cmd_ready = cmdReady;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = HBURST_SINGLE;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;

`ifndef SYNTHESIS
    logic cmdLegal;
    always_comb begin
        cmdLegal = ((32'd8 << cmd_size) <= 32'(HDATA_WIDTH)) &&
                   ((cmd_addr & HADDR_WIDTH'((32'd1 << cmd_size) - 32'd1)) == '0);
    end

    aCmdLegal: assert property (@(posedge HCLK) disable iff (HRESET) cmd_valid |-> cmdLegal);
`endif

endmodule
